// File: rtl/acc_pkg.sv
// Shared definitions for the batch accumulator: FSM state encoding and
// datapath widths used by batch_accumulator and acc_adder.
package acc_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

endpackage : acc_pkg

// File: rtl/acc_adder.sv
// Combinational ripple adder for the accumulator datapath.
// Carry-in is fixed at zero; only the DATA_W-bit sum is produced, the
// carry-out is reconstructed by the caller from the operand/sum MSBs.
module acc_adder
    import acc_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    logic carry_s;

    // Bit-serial ripple chain from LSB to MSB.
    always_comb begin
        carry_s = 1'b0;
        sum     = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            sum[i]  = a[i] ^ b[i] ^ carry_s;
            carry_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
        end
    end

endmodule : acc_adder

// File: rtl/batch_accumulator.sv
// Batch accumulator: sums unsigned 8-bit terms into a batch that closes on
// in_last or after MAX_TERMS terms, then presents the sum until the
// consumer takes it.
// Optional feature: define ACC_SATURATE_EN to clamp the sum at 8'hFF and
// flag saturation on sum_sat; otherwise sums wrap modulo 256 and sum_sat
// stays 0.
module batch_accumulator
    import acc_pkg::*;
#(
    parameter int unsigned MAX_TERMS = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              sum_valid,
    output logic [DATA_W-1:0] sum_data,
    output logic [CNT_W-1:0]  sum_count,
    output logic              sum_sat,
    input  logic              sum_ready
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    acc_state_e        state_r;
    logic [DATA_W-1:0] acc_r;
    logic [CNT_W-1:0]  count_r;
    logic              sat_r;

    logic [DATA_W-1:0] add_sum_s;
    logic [DATA_W-1:0] acc_next_s;
    logic [CNT_W-1:0]  count_inc_s;
    logic              sat_next_s;
    logic              close_s;
    logic              accept_s;
    logic              in_ready_s;

    acc_adder u_adder (
        .a   (acc_r),
        .b   (in_data),
        .sum (add_sum_s)
    );

    // Terms are taken in IDLE/ACCUM only, and never while reset is held.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst_n && (state_r != HOLD)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid & in_ready_s;
    end

    // Next accumulator value, saturation flag and batch-close decision.
    always_comb begin
        acc_next_s  = add_sum_s;
        sat_next_s  = 1'b0;
        count_inc_s = count_r + 4'd1;
`ifdef ACC_SATURATE_EN
        begin : sat_blk
            logic carry_s;
            // Carry-out rebuilt from the MSBs of operands and sum.
            carry_s = (acc_r[DATA_W-1] & in_data[DATA_W-1])
                    | ((acc_r[DATA_W-1] | in_data[DATA_W-1]) & ~add_sum_s[DATA_W-1]);
            if (sat_r || carry_s) begin
                acc_next_s = 8'hFF;
                sat_next_s = 1'b1;
            end else begin
                acc_next_s = add_sum_s;
                sat_next_s = 1'b0;
            end
        end
`else
        acc_next_s = add_sum_s;
        sat_next_s = 1'b0;
`endif
        if (in_last || (count_inc_s == MAX_CNT)) begin
            close_s = 1'b1;
        end else begin
            close_s = 1'b0;
        end
    end

    // Batch FSM together with the accumulator, term counter and sat flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            acc_r   <= 8'd0;
            count_r <= 4'd0;
            sat_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, ACCUM: begin
                    if (accept_s) begin
                        acc_r   <= acc_next_s;
                        count_r <= count_inc_s;
                        sat_r   <= sat_next_s;
                        state_r <= close_s ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (sum_ready) begin
                        state_r <= IDLE;
                        acc_r   <= 8'd0;
                        count_r <= 4'd0;
                        sat_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    acc_r   <= 8'd0;
                    count_r <= 4'd0;
                    sat_r   <= 1'b0;
                end
            endcase
        end
    end

    // The result registers are frozen in HOLD, so they drive the outputs directly.
    always_comb begin
        in_ready  = in_ready_s;
        sum_valid = (state_r == HOLD);
        sum_data  = acc_r;
        sum_count = count_r;
        sum_sat   = sat_r;
    end

endmodule : batch_accumulator

// File: tb/tb_batch_accumulator.sv
// Self-checking bench for batch_accumulator with a result scoreboard.
module tb_batch_accumulator;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] count;
        logic       sat;
    } result_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       sum_valid;
    logic [7:0] sum_data;
    logic [3:0] sum_count;
    logic       sum_sat;
    logic       sum_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    result_t    exp_q[$];
    logic [7:0] m_acc = 8'd0;
    logic [3:0] m_cnt = 4'd0;
    logic       m_sat = 1'b0;

    batch_accumulator #(.MAX_TERMS(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sum_valid (sum_valid),
        .sum_data  (sum_data),
        .sum_count (sum_count),
        .sum_sat   (sum_sat),
        .sum_ready (sum_ready)
    );

    always #5 clk = ~clk;

    // Pop and compare every result the consumer takes.
    always @(negedge clk) begin
        result_t e;
        #2;
        if (rst_n && sum_valid && sum_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_unexpected: got data=%0d count=%0d sat=%0d, expected no result",
                         sum_data, sum_count, sum_sat);
            end else begin
                e = exp_q.pop_front();
                if ({sum_data, sum_count, sum_sat} !== {e.data, e.count, e.sat}) begin
                    failures++;
                    $display("FAIL scoreboard_result: got data=%0d count=%0d sat=%0d, expected data=%0d count=%0d sat=%0d",
                             sum_data, sum_count, sum_sat, e.data, e.count, e.sat);
                end
            end
        end
    end

    // Offer one term (waiting for in_ready) and advance the reference model.
    task automatic send_term(input logic [7:0] d, input logic last);
        logic [8:0] wide;
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: got in_ready=0, expected 1 within 100 cycles");
        end else begin
            in_valid = 1'b1;
            in_data  = d;
            in_last  = last;
            wide = {1'b0, m_acc} + {1'b0, d};
`ifdef ACC_SATURATE_EN
            if (m_sat || wide[8]) begin
                m_acc = 8'hFF;
                m_sat = 1'b1;
            end else begin
                m_acc = wide[7:0];
            end
`else
            m_acc = wide[7:0];
`endif
            m_cnt = m_cnt + 4'd1;
            if (last || m_cnt == 4'd15) begin
                exp_q.push_back('{data: m_acc, count: m_cnt, sat: m_sat});
                m_acc = 8'd0;
                m_cnt = 4'd0;
                m_sat = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, sum_valid, sum_data, sum_count, sum_sat} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%0b vld=%0b data=%0d cnt=%0d sat=%0b, expected all 0",
                     in_ready, sum_valid, sum_data, sum_count, sum_sat);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || sum_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%0b vld=%0b, expected rdy=1 vld=0", in_ready, sum_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        sum_ready = 1'b1;
        send_term(8'd3, 1'b0);
        send_term(8'd4, 1'b0);
        checks++;
        if (sum_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid: got sum_valid=%0b, expected 0", sum_valid);
        end
        send_term(8'd5, 1'b1);
        checks++;
        if ({sum_valid, sum_data, sum_count} !== {1'b1, 8'd12, 4'd3}) begin
            failures++;
            $display("FAIL basic_latency: got vld=%0b data=%0d cnt=%0d, expected vld=1 data=12 cnt=3",
                     sum_valid, sum_data, sum_count);
        end
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_return_idle: got vld=%0b rdy=%0b, expected vld=0 rdy=1", sum_valid, in_ready);
        end
    endtask

    task automatic test_overflow();
        send_term(8'd200, 1'b0);
        send_term(8'd100, 1'b1);
        checks++;
`ifdef ACC_SATURATE_EN
        if ({sum_data, sum_sat} !== {8'd255, 1'b1}) begin
            failures++;
            $display("FAIL overflow_sat: got data=%0d sat=%0b, expected data=255 sat=1", sum_data, sum_sat);
        end
`else
        if ({sum_data, sum_sat} !== {8'd44, 1'b0}) begin
            failures++;
            $display("FAIL overflow_wrap: got data=%0d sat=%0b, expected data=44 sat=0", sum_data, sum_sat);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_max_terms();
        for (int i = 0; i < 15; i++) begin
            send_term(8'd1, 1'b0);
        end
        checks++;
        if ({sum_valid, sum_data, sum_count} !== {1'b1, 8'd15, 4'd15}) begin
            failures++;
            $display("FAIL max_terms_close: got vld=%0b data=%0d cnt=%0d, expected vld=1 data=15 cnt=15",
                     sum_valid, sum_data, sum_count);
        end
        @(negedge clk);
    endtask

    task automatic test_hold_stall();
        sum_ready = 1'b0;
        send_term(8'd9, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd77;
            in_last  = 1'b1;
            checks++;
            if ({in_ready, sum_valid, sum_data, sum_count} !== {1'b0, 1'b1, 8'd9, 4'd1}) begin
                failures++;
                $display("FAIL hold_stable[%0d]: got rdy=%0b vld=%0b data=%0d cnt=%0d, expected rdy=0 vld=1 data=9 cnt=1",
                         i, in_ready, sum_valid, sum_data, sum_count);
            end
            @(negedge clk);
        end
        sum_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (sum_valid !== 1'b0 || in_ready !== 1'b1 || sum_count !== 4'd0) begin
            failures++;
            $display("FAIL hold_exit: got vld=%0b rdy=%0b cnt=%0d, expected vld=0 rdy=1 cnt=0",
                     sum_valid, in_ready, sum_count);
        end
        send_term(8'd1, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_batch();
        send_term(8'd10, 1'b0);
        send_term(8'd20, 1'b0);
        #3;
        rst_n = 1'b0;
        m_acc = 8'd0;
        m_cnt = 4'd0;
        m_sat = 1'b0;
        #1;
        checks++;
        if ({in_ready, sum_valid, sum_data, sum_count, sum_sat} !== 15'd0) begin
            failures++;
            $display("FAIL reset_mid_batch: got rdy=%0b vld=%0b data=%0d cnt=%0d sat=%0b, expected all 0",
                     in_ready, sum_valid, sum_data, sum_count, sum_sat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_term(8'd7, 1'b1);
        checks++;
        if ({sum_valid, sum_data, sum_count} !== {1'b1, 8'd7, 4'd1}) begin
            failures++;
            $display("FAIL reset_next_batch: got vld=%0b data=%0d cnt=%0d, expected vld=1 data=7 cnt=1",
                     sum_valid, sum_data, sum_count);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 20; b++) begin
            int len = $urandom_range(1, 5);
            for (int t = 0; t < len; t++) begin
                send_term(8'($urandom_range(0, 255)), (t == len - 1) ? 1'b1 : 1'b0);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_max_terms();
        test_hold_stall();
        test_reset_mid_batch();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending results, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_batch_accumulator
